prim_otp_emul: RTL and testbench
================================

# prim_otp_emul

Parametrised one-time-programmable memory emulation, replacing the single-word OTP model. It adds an explicit init sequence, multi-word (burst) read/program commands, and OR-only programming with an optional blank check. Every accepted command gets exactly one response carrying an error code. It sits behind the OTP controller as the macro stand-in for simulation and FPGA builds.

## Interface
- Width, 16, bits per OTP word
- Depth, 1024, number of words; AddrWidth = $clog2(Depth)
- SizeWidth, 2, burst-size field width; max burst NumWords = 2**SizeWidth
- InitCycles, 8, cycles spent in the init sequence (>= 1)
- clk_i  input  1  clock
- rst_i  input  1  reset, asynchronous, active-high
- ready_o  output  1  command accepted when ready_o & valid_i
- valid_i  input  1  command valid
- cmd_i  input  2  0 Read, 1 Write, 2 Init, 3 reserved (MacroError)
- size_i  input  SizeWidth  words in burst minus one
- addr_i  input  AddrWidth  first word address
- wdata_i  input  Width*NumWords  program data, word k at bits [k*Width +: Width]
- rvalid_o  output  1  one-cycle response strobe
- rdata_o  output  Width*NumWords  read data, same packing; words beyond size are 0
- err_o  output  3  response error, valid with rvalid_o
- init_done_o  output  1  macro initialised

## Operation
- Error codes: 0 NoError, 1 MacroError, 4 MacroWriteBlankError.
- FSM states and transitions:
  - ResetSt: entered on reset. Accepts only Init → InitSt. Any other command → RespSt with MacroError, no array access.
  - InitSt: counts InitCycles, then → RespSt with NoError, and sets init_done_o.
  - IdleSt: dispatches Read → ReadSt and Write → WrRdSt. Init, cmd 3, or addr_i+size_i > Depth-1 → RespSt with MacroError, no array access.
  - ReadSt: reads one word per cycle into rdata_o word k, for size_i+1 cycles, then → RespSt.
  - WrRdSt / WrSt: for each word, WrRdSt reads the old value and WrSt writes mem[a] <= old | wdata_k. After the last word → RespSt.
  - RespSt: rvalid_o=1 for one cycle, then → IdleSt (or ResetSt if init_done_o=0).
- ready_o=1 only in ResetSt and IdleSt. Command fields are captured at acceptance; input changes after that are ignored.
- Bits can only be set, never cleared. The array is not reset.
- On a Read, rdata_o is cleared at acceptance and holds its value until the next Read is accepted. Write, Init and error responses leave rdata_o unchanged.
- Address arithmetic is done at AddrWidth+1 bits, so the bounds check never wraps.

## Timing
- Reset values: ready_o=1, rvalid_o=0, rdata_o=0, err_o=0, init_done_o=0, state ResetSt.
- Acceptance is at edge E0. Latency to the rvalid_o cycle:
  - Read: N+1 cycles, where N = size_i+1.
  - Write: 2N+1 cycles.
  - Init: InitCycles+1 cycles.
  - Error response: 1 cycle.
- The next command can be accepted the cycle after rvalid_o.
- Reset asserted mid-operation:
  - Immediately returns to ResetSt, clears init_done_o, and issues no response.
  - Words already programmed remain programmed; the current word's write does not occur unless its WrSt edge has passed.
  - Init is required again after reset.

## Configuration
- OTP_EMUL_BLANK_CHECK_EN defined: in WrRdSt, if (old & ~wdata_k) != 0, a sticky error flag is set and the OR-write still happens. The response carries MacroWriteBlankError (4); remaining words continue to be processed.
- Not defined: no check is made, and Write responses always carry NoError unless a MacroError applies.

## Structure
- Package prim_otp_emul_pkg holds:
  - the cmd_e enum (Read/Write/Init);
  - the err_e enum (3-bit, values above);
  - the shared width constant for err_o.
- The FSM state enum is local to the module.
- One sub-module, prim_otp_emul_array: single-port Depth x Width array with synchronous read, write enable, and no reset. It is backdoor-loadable with $readmemh under OTP_INIT_FILE.

## Test plan
- Read at addr 0 before Init → MacroError (1) one cycle after acceptance, init_done_o=0. Then Init → rvalid_o after 9 cycles, err 0, init_done_o=1.
- Write size_i=3, addr 0x10, data words 0x0001,0x0002,0x0004,0x0008 → rvalid_o after 9 cycles, err 0. Read size 3 from 0x10 returns the same words after 5 cycles.
- Write 0x00F0 then 0x000F to addr 0x20 → readback 0x00FF. Err on the second write: 4 with OTP_EMUL_BLANK_CHECK_EN, 0 without.
- Read size_i=3 at addr 1022 (Depth 1024) → MacroError after 1 cycle, rdata_o unchanged. size_i=1 at addr 1022 → err 0.
- Assert rst_i during the third word of a 4-word write of 0xFFFF → state ResetSt, no rvalid_o, init_done_o=0. After re-init, words 0–1 read 0xFFFF and word 3 reads 0.
- Hold valid_i high with varying addr_i while busy → exactly one response per accepted command. Fields captured at E0 are the ones used.

Source files
------------

// File: rtl/prim_otp_emul_pkg.sv
// Shared types for the OTP macro emulation: command and response-error encodings.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package prim_otp_emul_pkg;

  // Width of the response error code carried on err_o.
  localparam int ErrWidth = 3;

  // Command code 3 is deliberately left out; it is answered with MacroError.
  typedef enum logic [1:0] {
    CmdRead  = 2'd0,
    CmdWrite = 2'd1,
    CmdInit  = 2'd2
  } cmd_e;

  typedef enum logic [ErrWidth-1:0] {
    NoError              = 3'd0,
    MacroError           = 3'd1,
    MacroWriteBlankError = 3'd4
  } err_e;

endpackage

// File: rtl/prim_otp_emul_array.sv
// Single-port Depth x Width storage for the OTP emulation, synchronous read, no reset.
// Latency: read data appears the cycle after a read request; writes land on the request edge.
// Backpressure: none, one access per cycle when req_i is high.
// Ports: clk_i clock; req_i access enable; we_i write (else read); addr_i word address;
//        wdata_i write word; rdata_o registered read word (holds between reads).
module prim_otp_emul_array
  import prim_otp_emul_pkg::*;
#(
  parameter int Width = 16,
  parameter int Depth = 1024,
  localparam int AddrWidth = $clog2(Depth)
) (
  input  logic                 clk_i,
  input  logic                 req_i,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [Width-1:0]     wdata_i,
  output logic [Width-1:0]     rdata_o
);

  logic [Width-1:0] mem [Depth];

  // The read register only updates on reads so the old word stays visible
  // during the following write cycle of a read-modify-write.
  always_ff @(posedge clk_i) begin
    if (req_i) begin
      if (we_i) begin
        mem[addr_i] <= wdata_i;
      end else begin
        rdata_o <= mem[addr_i];
      end
    end
  end

endmodule

// File: rtl/prim_otp_emul.sv
// OTP macro emulation: init sequence, burst read, OR-only burst program, one response per command.
// Latency from acceptance to rvalid_o: read N+1, write 2N+1, init InitCycles+1, error 1 (N = size_i+1).
// Backpressure: ready_o is high only while idle (before or after init); commands are captured on acceptance.
// Ports: clk_i/rst_i (async, active-high); valid_i/ready_o command handshake with cmd_i, size_i,
//        addr_i, wdata_i; rvalid_o strobe with err_o and rdata_o; init_done_o macro initialised.
// Optional feature: define OTP_EMUL_BLANK_CHECK_EN to flag writes that try to clear programmed bits.
module prim_otp_emul
  import prim_otp_emul_pkg::*;
#(
  parameter int Width      = 16,
  parameter int Depth      = 1024,
  parameter int SizeWidth  = 2,
  parameter int InitCycles = 8,
  localparam int AddrWidth = $clog2(Depth),
  localparam int NumWords  = 2**SizeWidth
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  output logic                      ready_o,
  input  logic                      valid_i,
  input  logic [1:0]                cmd_i,
  input  logic [SizeWidth-1:0]      size_i,
  input  logic [AddrWidth-1:0]      addr_i,
  input  logic [Width*NumWords-1:0] wdata_i,
  output logic                      rvalid_o,
  output logic [Width*NumWords-1:0] rdata_o,
  output logic [ErrWidth-1:0]       err_o,
  output logic                      init_done_o
);

  localparam logic [2:0] ResetSt = 3'd0;
  localparam logic [2:0] InitSt  = 3'd1;
  localparam logic [2:0] IdleSt  = 3'd2;
  localparam logic [2:0] ReadSt  = 3'd3;
  localparam logic [2:0] WrRdSt  = 3'd4;
  localparam logic [2:0] WrSt    = 3'd5;
  localparam logic [2:0] RespSt  = 3'd6;

  localparam int InitCntW = $clog2(InitCycles + 1);
  localparam logic [InitCntW-1:0]  InitLast = InitCntW'(InitCycles - 1);
  localparam logic [InitCntW-1:0]  InitOne  = InitCntW'(1);
  localparam logic [SizeWidth-1:0] SizeOne  = SizeWidth'(1);
  localparam logic [AddrWidth-1:0] AddrOne  = AddrWidth'(1);
  localparam logic [AddrWidth:0]   AddrLast = (AddrWidth+1)'(Depth - 1);

  logic [2:0]                      state_q;
  logic [SizeWidth-1:0]            size_q;
  logic [SizeWidth-1:0]            cnt_q;
  logic [AddrWidth-1:0]            addr_q;
  logic [NumWords-1:0][Width-1:0]  wdata_q;
  logic [NumWords-1:0][Width-1:0]  rdata_q;
  logic [ErrWidth-1:0]             err_q;
  logic                            blank_q;
  logic                            init_done_q;
  logic [InitCntW-1:0]             init_cnt_q;

  logic                 accept;
  logic                 in_range;
  logic                 last_word;
  logic                 blank_hit;
  logic                 arr_req;
  logic                 arr_we;
  logic [AddrWidth-1:0] arr_addr;
  logic [Width-1:0]     arr_wdata;
  logic [Width-1:0]     arr_rdata;

  assign ready_o     = (state_q == ResetSt) || (state_q == IdleSt);
  assign accept      = ready_o & valid_i;
  // One extra bit so a burst running past the top of the array is caught, not wrapped.
  assign in_range    = ({1'b0, addr_i} + (AddrWidth+1)'(size_i)) <= AddrLast;
  assign last_word   = (cnt_q == size_q);
  assign rvalid_o    = (state_q == RespSt);
  assign rdata_o     = rdata_q;
  assign err_o       = err_q;
  assign init_done_o = init_done_q;

`ifdef OTP_EMUL_BLANK_CHECK_EN
  // Any bit set in the stored word but not in the new data would need clearing.
  assign blank_hit = (state_q == WrSt) && (|(arr_rdata & ~wdata_q[cnt_q]));
`else
  assign blank_hit = 1'b0;
`endif

  // Array access: the first read word is requested straight from addr_i on
  // acceptance so each ReadSt cycle can capture one word and prefetch the next.
  always_comb begin
    arr_req   = 1'b0;
    arr_we    = 1'b0;
    arr_addr  = addr_q;
    arr_wdata = arr_rdata | wdata_q[cnt_q];
    case (state_q)
      IdleSt: begin
        arr_addr = addr_i;
        arr_req  = accept && (cmd_i == CmdRead) && in_range;
      end
      ReadSt: begin
        arr_addr = addr_q + AddrOne;
        arr_req  = !last_word;
      end
      WrRdSt: arr_req = 1'b1;
      WrSt: begin
        arr_req = 1'b1;
        arr_we  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ResetSt;
      size_q      <= '0;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      err_q       <= NoError;
      blank_q     <= 1'b0;
      init_done_q <= 1'b0;
      init_cnt_q  <= '0;
    end else begin
      case (state_q)
        // ResetSt and IdleSt differ only in init_done_q, so they share dispatch.
        ResetSt, IdleSt: begin
          if (accept) begin
            size_q     <= size_i;
            addr_q     <= addr_i;
            wdata_q    <= wdata_i;
            cnt_q      <= '0;
            init_cnt_q <= '0;
            blank_q    <= 1'b0;
            state_q    <= RespSt;
            err_q      <= MacroError;
            if (!init_done_q) begin
              if (cmd_i == CmdInit) begin
                state_q <= InitSt;
              end
            end else if (in_range) begin
              if (cmd_i == CmdRead) begin
                state_q <= ReadSt;
                rdata_q <= '0;
              end else if (cmd_i == CmdWrite) begin
                state_q <= WrRdSt;
              end
            end
          end
        end
        InitSt: begin
          if (init_cnt_q == InitLast) begin
            state_q     <= RespSt;
            err_q       <= NoError;
            init_done_q <= 1'b1;
          end else begin
            init_cnt_q <= init_cnt_q + InitOne;
          end
        end
        ReadSt: begin
          rdata_q[cnt_q] <= arr_rdata;
          if (last_word) begin
            state_q <= RespSt;
            err_q   <= NoError;
          end else begin
            cnt_q  <= cnt_q + SizeOne;
            addr_q <= addr_q + AddrOne;
          end
        end
        WrRdSt: state_q <= WrSt;
        WrSt: begin
          // The error is sticky across the burst; the OR-write still happens.
          blank_q <= blank_q | blank_hit;
          if (last_word) begin
            state_q <= RespSt;
            err_q   <= (blank_q | blank_hit) ? MacroWriteBlankError : NoError;
          end else begin
            cnt_q   <= cnt_q + SizeOne;
            addr_q  <= addr_q + AddrOne;
            state_q <= WrRdSt;
          end
        end
        RespSt:  state_q <= init_done_q ? IdleSt : ResetSt;
        default: state_q <= ResetSt;
      endcase
    end
  end

  prim_otp_emul_array #(
    .Width (Width),
    .Depth (Depth)
  ) u_array (
    .clk_i   (clk_i),
    .req_i   (arr_req),
    .we_i    (arr_we),
    .addr_i  (arr_addr),
    .wdata_i (arr_wdata),
    .rdata_o (arr_rdata)
  );

endmodule

// File: tb/tb_prim_otp_emul.sv
// Bench for prim_otp_emul: transaction-level model of the OTP (word array, per-command
// latency and error rules) compared against the DUT outputs every cycle, plus directed
// literal checks and a randomized phase with valid_i held high.
module tb_prim_otp_emul;
  import prim_otp_emul_pkg::*;

  localparam int W    = 16;
  localparam int D    = 1024;
  localparam int NW   = 4;
  localparam int WB   = W * NW;
  localparam int ICYC = 8;

  logic          clk_i   = 1'b0;
  logic          rst_i   = 1'b1;
  logic          valid_i = 1'b0;
  logic [1:0]    cmd_i   = 2'd0;
  logic [1:0]    size_i  = 2'd0;
  logic [9:0]    addr_i  = 10'd0;
  logic [WB-1:0] wdata_i = '0;
  logic          ready_o;
  logic          rvalid_o;
  logic          init_done_o;
  logic [WB-1:0] rdata_o;
  logic [2:0]    err_o;

  always #5 clk_i = ~clk_i;

  prim_otp_emul dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .ready_o     (ready_o),
    .valid_i     (valid_i),
    .cmd_i       (cmd_i),
    .size_i      (size_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .rvalid_o    (rvalid_o),
    .rdata_o     (rdata_o),
    .err_o       (err_o),
    .init_done_o (init_done_o)
  );

  int n_chk = 0;
  int n_err = 0;

  function automatic void chk(string nm, logic [WB-1:0] act, logic [WB-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void tmo(string nm);
    n_chk++;
    n_err++;
    $display("FAIL %s: timed out at %0t", nm, $time);
  endfunction

  // ---------------- behavioural model ----------------
  typedef struct packed {
    int         cyc;
    int         a;
    logic [W-1:0] d;
  } wr_t;

  logic [W-1:0] mem_m [D];
  wr_t          pend[$];
  wr_t          wr_tmp;
  int           cyc = 0, m_resp_cyc = 0, m_acc_cyc = -1;
  int           n_acc = 0, n_resp = 0, n_kill = 0;
  int           m_n, m_lat, m_a;
  bit           m_acc, m_busy = 0, m_is_read = 0, m_set_init = 0, m_init_done = 0, m_blank;
  logic [2:0]   m_err = 3'd0;
  logic [WB-1:0] m_rdata = '0;

  // Blank emulated OTP.
  initial for (int i = 0; i < D; i++) mem_m[i] = '0;

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      if (m_busy) n_kill++;
      m_busy      = 0;
      m_init_done = 0;
      m_rdata     = '0;
      pend.delete();
    end else begin
      m_acc = valid_i && !m_busy;
      cyc++;
      // Word k of a write is programmed 2k+2 edges after acceptance.
      while (pend.size() > 0 && pend[0].cyc == cyc) begin
        mem_m[pend[0].a] = mem_m[pend[0].a] | pend[0].d;
        void'(pend.pop_front());
      end
      if (m_busy && cyc == m_resp_cyc && m_set_init) m_init_done = 1;
      if (m_busy && cyc == m_resp_cyc + 1) m_busy = 0;
      if (m_acc) begin
        m_n        = int'(size_i) + 1;
        m_a        = int'(addr_i);
        m_lat      = 1;
        m_err      = 3'd1;
        m_is_read  = 0;
        m_set_init = 0;
        if (!m_init_done) begin
          if (cmd_i == 2'd2) begin
            m_lat      = ICYC + 1;
            m_err      = 3'd0;
            m_set_init = 1;
          end
        end else if (m_a + m_n - 1 <= D - 1) begin
          if (cmd_i == 2'd0) begin
            m_lat     = m_n + 1;
            m_err     = 3'd0;
            m_is_read = 1;
            m_rdata   = '0;
            for (int k = 0; k < m_n; k++) m_rdata[k*W +: W] = mem_m[m_a + k];
          end else if (cmd_i == 2'd1) begin
            m_lat   = 2 * m_n + 1;
            m_err   = 3'd0;
            m_blank = 0;
            for (int k = 0; k < m_n; k++) begin
              if ((mem_m[m_a + k] & ~wdata_i[k*W +: W]) != '0) m_blank = 1;
              wr_tmp.cyc = cyc + 2 * k + 2;
              wr_tmp.a   = m_a + k;
              wr_tmp.d   = wdata_i[k*W +: W];
              pend.push_back(wr_tmp);
            end
`ifdef OTP_EMUL_BLANK_CHECK_EN
            m_err = m_blank ? 3'd4 : 3'd0;
`endif
          end
        end
        m_busy     = 1;
        m_resp_cyc = cyc + m_lat - 1;
        m_acc_cyc  = cyc;
        n_acc++;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  bit exp_rv;
  always @(negedge clk_i) begin
    exp_rv = m_busy && (cyc == m_resp_cyc) && !rst_i;
    if (rvalid_o) n_resp++;
    chk("ready", WB'(ready_o), WB'(rst_i || !m_busy));
    chk("rvalid", WB'(rvalid_o), WB'(exp_rv));
    chk("init_done", WB'(init_done_o), WB'(m_init_done));
    if (exp_rv) begin
      chk("err", WB'(err_o), WB'(m_err));
      chk("rdata_resp", rdata_o, m_rdata);
    end else if (!(m_busy && m_is_read)) begin
      chk("rdata_hold", rdata_o, m_rdata);
    end
  end

  // ---------------- driver ----------------
  task automatic send(input logic [1:0] c, input logic [1:0] sz, input logic [9:0] a,
                      input logic [WB-1:0] wd, output int lat, output logic [2:0] e,
                      output logic [WB-1:0] rd, output logic idn);
    bit got;
    lat = 0; e = '0; rd = '0; idn = 1'b0;
    @(negedge clk_i);
    valid_i = 1'b1; cmd_i = c; size_i = sz; addr_i = a; wdata_i = wd;
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(posedge clk_i); #1;
      if (m_acc_cyc == cyc) got = 1;
    end
    // Scramble the fields so the DUT must rely on what it captured.
    valid_i = 1'b0;
    cmd_i   = 2'($urandom);
    size_i  = 2'($urandom);
    addr_i  = 10'($urandom);
    wdata_i = {$urandom, $urandom};
    if (!got) begin
      tmo("accept");
      return;
    end
    got = 0;
    for (int i = 1; i <= 60 && !got; i++) begin
      @(negedge clk_i);
      if (rvalid_o) begin
        got = 1; lat = i; e = err_o; rd = rdata_o; idn = init_done_o;
      end
    end
    if (!got) tmo("response");
  endtask

  int            lat;
  logic [2:0]    e;
  logic [WB-1:0] rd, wd;
  logic          idn;
  int            r, c0;
  bit            got;

  initial begin
    repeat (3) @(negedge clk_i);
    chk("rst_ready", WB'(ready_o), WB'(1));
    chk("rst_rvalid", WB'(rvalid_o), WB'(0));
    chk("rst_rdata", rdata_o, WB'(0));
    chk("rst_err", WB'(err_o), WB'(0));
    chk("rst_init_done", WB'(init_done_o), WB'(0));
    rst_i = 1'b0;

    send(2'd0, 2'd0, 10'd0, '0, lat, e, rd, idn);
    chk("preinit_lat", WB'(lat), WB'(1));
    chk("preinit_err", WB'(e), WB'(1));
    chk("preinit_idn", WB'(idn), WB'(0));

    send(2'd2, 2'd0, 10'd0, '0, lat, e, rd, idn);
    chk("init_lat", WB'(lat), WB'(9));
    chk("init_err", WB'(e), WB'(0));
    chk("init_idn", WB'(idn), WB'(1));

    wd = {16'h0008, 16'h0004, 16'h0002, 16'h0001};
    send(2'd1, 2'd3, 10'h010, wd, lat, e, rd, idn);
    chk("wr4_lat", WB'(lat), WB'(9));
    chk("wr4_err", WB'(e), WB'(0));
    send(2'd0, 2'd3, 10'h010, '0, lat, e, rd, idn);
    chk("rd4_lat", WB'(lat), WB'(5));
    chk("rd4_data", rd, 64'h0008_0004_0002_0001);

    send(2'd0, 2'd3, 10'd1022, '0, lat, e, rd, idn);
    chk("oob_lat", WB'(lat), WB'(1));
    chk("oob_err", WB'(e), WB'(1));
    chk("oob_rdata_kept", rd, 64'h0008_0004_0002_0001);
    send(2'd0, 2'd1, 10'd1022, '0, lat, e, rd, idn);
    chk("top_lat", WB'(lat), WB'(3));
    chk("top_err", WB'(e), WB'(0));
    chk("top_data", rd, 64'h0);

    send(2'd1, 2'd0, 10'h020, 64'h00F0, lat, e, rd, idn);
    chk("or1_lat", WB'(lat), WB'(3));
    chk("or1_err", WB'(e), WB'(0));
    send(2'd1, 2'd0, 10'h020, 64'h000F, lat, e, rd, idn);
`ifdef OTP_EMUL_BLANK_CHECK_EN
    chk("or2_err", WB'(e), WB'(4));
`else
    chk("or2_err", WB'(e), WB'(0));
`endif
    send(2'd0, 2'd0, 10'h020, '0, lat, e, rd, idn);
    chk("or_lat", WB'(lat), WB'(2));
    chk("or_data", rd, 64'h00FF);
    chk("model_pin_20", WB'(mem_m[10'h020]), WB'(16'h00FF));
    chk("model_pin_13", WB'(mem_m[10'h013]), WB'(16'h0008));

    // Randomized stream with valid_i held high while busy.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk_i);
      valid_i = 1'b1;
      r = int'($urandom_range(0, 9));
      cmd_i  = (r < 4) ? 2'd0 : (r < 8) ? 2'd1 : (r == 8) ? 2'd2 : 2'd3;
      size_i = 2'($urandom);
      addr_i = ($urandom_range(0, 7) == 0) ? 10'(1020 + $urandom_range(0, 3))
                                           : 10'(256 + $urandom_range(0, 31));
      wdata_i = {$urandom & $urandom & $urandom, $urandom & $urandom & $urandom};
    end
    @(negedge clk_i);
    valid_i = 1'b0;
    for (int i = 0; i < 100 && m_busy; i++) @(negedge clk_i);
    if (m_busy) tmo("drain");

    // Reset during the third word of a 4-word write.
    @(negedge clk_i);
    valid_i = 1'b1; cmd_i = 2'd1; size_i = 2'd3; addr_i = 10'h040; wdata_i = {4{16'hFFFF}};
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk_i); #1;
      if (m_acc_cyc == cyc) got = 1;
    end
    valid_i = 1'b0;
    if (!got) tmo("rst_wr_accept");
    c0 = cyc;
    repeat (4) @(posedge clk_i);
    #2 rst_i = 1'b1;
    @(negedge clk_i);
    chk("midrst_ready", WB'(ready_o), WB'(1));
    chk("midrst_rvalid", WB'(rvalid_o), WB'(0));
    chk("midrst_idn", WB'(init_done_o), WB'(0));
    chk("midrst_edges", WB'(cyc - c0), WB'(4));
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (20) @(negedge clk_i);

    send(2'd2, 2'd0, 10'd0, '0, lat, e, rd, idn);
    chk("reinit_lat", WB'(lat), WB'(9));
    chk("reinit_idn", WB'(idn), WB'(1));
    send(2'd0, 2'd3, 10'h040, '0, lat, e, rd, idn);
    chk("rst_w0", WB'(rd[15:0]), WB'(16'hFFFF));
    chk("rst_w1", WB'(rd[31:16]), WB'(16'hFFFF));
    chk("rst_w3", WB'(rd[63:48]), WB'(16'h0000));

    repeat (2) @(negedge clk_i);
    chk("resp_count", WB'(n_resp), WB'(n_acc - n_kill));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
